// File: rtl/ctrl_rw_pipe.sv
// CAS data-window tracker: queues RD/WR commands, counts down their latency and launches bursts in issue order.
// Strobes appear one clock after a countdown expires; a head blocked by an active burst stalls in place.
module ctrl_rw_pipe #(
  parameter int DEPTH = 8,
  parameter int LAT_W = 7
) (
  input  logic                         CK_t,
  input  logic                         reset,
  input  logic                         cas_rdy,
  input  logic [2:0]                   cas_req,
  input  logic                         bc4,
  input  logic [4:0]                   CL,
  input  logic [4:0]                   CWL,
  input  logic [4:0]                   AL,
  input  logic [1:0]                   RD_PRE,
  input  logic [1:0]                   WR_PRE,
  output logic                         rd_rdy,
  output logic                         rda_rdy,
  output logic                         wr_rdy,
  output logic                         wra_rdy,
  output logic                         data_active,
  output logic                         rw_done,
  output logic                         data_idle,
  output logic [$clog2(DEPTH+1)-1:0]   q_count,
  output logic                         q_full,
  output logic                         overflow_err,
  output logic                         collision_err,
  output logic                         order_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;
  localparam logic [2:0] CMD_RD  = 3'd1;
  localparam logic [2:0] CMD_RDA = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_WRA = 3'd4;

  logic [LAT_W-1:0] ent_cnt [DEPTH];
  logic [2:0]       ent_typ [DEPTH];
  logic             ent_bc4 [DEPTH];
  logic [LAT_W-1:0] nxt_cnt [DEPTH];
  logic [2:0]       nxt_typ [DEPTH];
  logic             nxt_bc4 [DEPTH];

  logic [CW-1:0]    count, count_nxt, wr_idx;
  logic [0:0]       state, state_nxt;
  logic [1:0]       beat, beat_nxt;
  logic             cur_bc4, bc4_nxt;

  logic             is_cas, is_rd, head_ready, last_beat, launch, push_ok, ord_hit;
  logic [LAT_W-1:0] rd_lat, wr_lat, push_lat, push_cnt;

  function automatic logic [LAT_W-1:0] dec(input logic [LAT_W-1:0] v);
    return (v == '0) ? v : v - LAT_W'(1);
  endfunction

  assign is_cas   = cas_rdy && (cas_req >= CMD_RD) && (cas_req <= CMD_WRA);
  assign is_rd    = (cas_req == CMD_RD) || (cas_req == CMD_RDA);
  assign rd_lat   = LAT_W'(CL) + LAT_W'(AL) + LAT_W'(RD_PRE);
  assign wr_lat   = LAT_W'(CWL) + LAT_W'(AL) + LAT_W'(WR_PRE);
  assign push_lat = is_rd ? rd_lat : wr_lat;
  assign push_cnt = (push_lat == '0) ? LAT_W'(1) : push_lat;

  // "Ready" means the countdown will read 0 after this edge.
  assign head_ready = (count != '0) && (ent_cnt[0] <= LAT_W'(1));
  assign last_beat  = (state == ST_BURST) && (beat == (cur_bc4 ? 2'd1 : 2'd3));
  assign launch     = head_ready && ((state == ST_IDLE) || last_beat);
  assign push_ok    = is_cas && ((count != FULL) || launch);
  assign wr_idx     = launch ? count - CW'(1) : count;

  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++) begin
      nxt_cnt[i] = launch ? dec(ent_cnt[i+1]) : dec(ent_cnt[i]);
      nxt_typ[i] = launch ? ent_typ[i+1] : ent_typ[i];
      nxt_bc4[i] = launch ? ent_bc4[i+1] : ent_bc4[i];
    end
    nxt_cnt[DEPTH-1] = dec(ent_cnt[DEPTH-1]);
    nxt_typ[DEPTH-1] = ent_typ[DEPTH-1];
    nxt_bc4[DEPTH-1] = ent_bc4[DEPTH-1];
    for (int i = 0; i < DEPTH; i++) begin
      if (push_ok && (CW'(i) == wr_idx)) begin
        nxt_cnt[i] = push_cnt;
        nxt_typ[i] = cas_req;
        nxt_bc4[i] = bc4;
      end
    end
  end

  always_comb begin
    ord_hit = 1'b0;
    for (int i = 1; i < DEPTH; i++) begin
      if ((CW'(i) < count) && (ent_cnt[i] <= LAT_W'(1)) && (ent_cnt[0] > LAT_W'(1)))
        ord_hit = 1'b1;
    end
  end

  always_comb begin
    count_nxt = count;
    if (push_ok && !launch)
      count_nxt = count + CW'(1);
    else if (!push_ok && launch)
      count_nxt = count - CW'(1);
  end

  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    bc4_nxt   = cur_bc4;
    if (launch) begin
      state_nxt = ST_BURST;
      beat_nxt  = 2'd0;
      bc4_nxt   = ent_bc4[0];
    end else if (last_beat) begin
      state_nxt = ST_IDLE;
      beat_nxt  = 2'd0;
    end else if (state == ST_BURST) begin
      beat_nxt  = beat + 2'd1;
    end
  end

  always_ff @(posedge CK_t or posedge reset) begin
    if (reset) begin
      count         <= '0;
      state         <= ST_IDLE;
      beat          <= 2'd0;
      cur_bc4       <= 1'b0;
      rd_rdy        <= 1'b0;
      rda_rdy       <= 1'b0;
      wr_rdy        <= 1'b0;
      wra_rdy       <= 1'b0;
      data_idle     <= 1'b1;
      q_full        <= 1'b0;
      overflow_err  <= 1'b0;
      collision_err <= 1'b0;
      order_err     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_cnt[i] <= '0;
        ent_typ[i] <= 3'd0;
        ent_bc4[i] <= 1'b0;
      end
    end else begin
      count   <= count_nxt;
      state   <= state_nxt;
      beat    <= beat_nxt;
      cur_bc4 <= bc4_nxt;
      for (int i = 0; i < DEPTH; i++) begin
        ent_cnt[i] <= nxt_cnt[i];
        ent_typ[i] <= nxt_typ[i];
        ent_bc4[i] <= nxt_bc4[i];
      end
      rd_rdy        <= launch && (ent_typ[0] == CMD_RD);
      rda_rdy       <= launch && (ent_typ[0] == CMD_RDA);
      wr_rdy        <= launch && (ent_typ[0] == CMD_WR);
      wra_rdy       <= launch && (ent_typ[0] == CMD_WRA);
      data_idle     <= (count_nxt == '0) && (state_nxt == ST_IDLE);
      q_full        <= (count_nxt == FULL);
      overflow_err  <= overflow_err | (is_cas && (count == FULL) && !launch);
      collision_err <= collision_err | (head_ready && (state == ST_BURST) && !last_beat);
      order_err     <= order_err | ord_hit;
    end
  end

  assign q_count     = count;
  assign data_active = (state == ST_BURST);
  assign rw_done     = last_beat;

endmodule

// File: tb/tb_ctrl_rw_pipe.sv
// Bench for ctrl_rw_pipe: directed scenarios plus randomized traffic against a timeline model.
module tb_ctrl_rw_pipe;
  localparam int DEPTH = 8;

  logic       CK_t = 1'b0;
  logic       reset = 1'b1;
  logic       cas_rdy = 1'b0;
  logic [2:0] cas_req = 3'd0;
  logic       bc4 = 1'b0;
  logic [4:0] CL = 5'd0, CWL = 5'd0, AL = 5'd0;
  logic [1:0] RD_PRE = 2'd0, WR_PRE = 2'd0;
  logic       rd_rdy, rda_rdy, wr_rdy, wra_rdy, data_active, rw_done, data_idle;
  logic [3:0] q_count;
  logic       q_full, overflow_err, collision_err, order_err;

  ctrl_rw_pipe #(.DEPTH(DEPTH), .LAT_W(7)) dut (
    .CK_t(CK_t), .reset(reset), .cas_rdy(cas_rdy), .cas_req(cas_req), .bc4(bc4),
    .CL(CL), .CWL(CWL), .AL(AL), .RD_PRE(RD_PRE), .WR_PRE(WR_PRE),
    .rd_rdy(rd_rdy), .rda_rdy(rda_rdy), .wr_rdy(wr_rdy), .wra_rdy(wra_rdy),
    .data_active(data_active), .rw_done(rw_done), .data_idle(data_idle),
    .q_count(q_count), .q_full(q_full), .overflow_err(overflow_err),
    .collision_err(collision_err), .order_err(order_err)
  );

  always #5 CK_t = ~CK_t;

  int cyc = 0;
  always @(posedge CK_t) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;

  // Observed events, tagged with the index of the edge that produced them.
  int o_edge[$], o_typ[$], done_edge[$], act_edge[$];
  always @(negedge CK_t) begin
    if (!reset) begin
      if (rd_rdy)  begin o_edge.push_back(cyc); o_typ.push_back(1); end
      if (rda_rdy) begin o_edge.push_back(cyc); o_typ.push_back(2); end
      if (wr_rdy)  begin o_edge.push_back(cyc); o_typ.push_back(3); end
      if (wra_rdy) begin o_edge.push_back(cyc); o_typ.push_back(4); end
      if (rw_done) done_edge.push_back(cyc);
      if (data_active) act_edge.push_back(cyc);
    end
  end

  int p_edge[$], p_typ[$], p_bc4[$];
  int m_push[$], m_ready[$], m_launch[$], m_typ[$], m_len[$];
  bit m_ovf, m_coll, m_ord;

  task automatic clear_logs;
    o_edge.delete(); o_typ.delete(); done_edge.delete(); act_edge.delete();
    p_edge.delete(); p_typ.delete(); p_bc4.delete();
  endtask

  task automatic apply_reset;
    @(negedge CK_t);
    reset = 1'b1; cas_rdy = 1'b0;
    repeat (2) @(negedge CK_t);
    reset = 1'b0;
    clear_logs();
  endtask

  // Called at a falling edge; the command is sampled on the next rising edge.
  task automatic push(input int code, input int b);
    cas_rdy = 1'b1; cas_req = 3'(code); bc4 = (b != 0);
    if (code >= 1 && code <= 4) begin
      p_edge.push_back(cyc + 1); p_typ.push_back(code); p_bc4.push_back(b);
    end
    @(negedge CK_t);
    cas_rdy = 1'b0; cas_req = 3'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CK_t);
  endtask

  function automatic int lat_of(input int code);
    int d;
    d = (code <= 2) ? int'(CL) + int'(AL) + int'(RD_PRE) : int'(CWL) + int'(AL) + int'(WR_PRE);
    return (d == 0) ? 1 : d;
  endfunction

  // Timeline model: each burst starts at max(ready time, end of previous burst).
  task automatic model_run;
    int prev_end, occ, r, l, len, h, last;
    bit pop;
    m_push.delete(); m_ready.delete(); m_launch.delete(); m_typ.delete(); m_len.delete();
    m_ovf = 0; m_coll = 0; m_ord = 0; prev_end = 0;
    for (int i = 0; i < p_edge.size(); i++) begin
      occ = 0; pop = 0;
      for (int j = 0; j < m_launch.size(); j++) begin
        if (m_launch[j] >= p_edge[i]) occ++;
        if (m_launch[j] == p_edge[i]) pop = 1;
      end
      if (occ >= DEPTH && !pop) m_ovf = 1;
      else begin
        r = p_edge[i] + lat_of(p_typ[i]);
        l = (r > prev_end) ? r : prev_end;
        len = (p_bc4[i] != 0) ? 2 : 4;
        if (l > r) m_coll = 1;
        m_push.push_back(p_edge[i]); m_ready.push_back(r); m_launch.push_back(l);
        m_typ.push_back(p_typ[i]); m_len.push_back(len);
        prev_end = l + len;
      end
    end
    if (m_launch.size() > 0) begin
      last = m_launch[m_launch.size()-1];
      for (int t = m_push[0]; t <= last; t++) begin
        h = -1;
        for (int j = 0; j < m_launch.size(); j++) begin
          if (m_push[j] < t && m_launch[j] >= t) begin
            if (h < 0) h = j;
            else if (m_ready[j] <= t && m_ready[h] > t) m_ord = 1;
          end
        end
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge CK_t);
    #1;
    n_checks++; if ({rd_rdy, rda_rdy, wr_rdy, wra_rdy} !== 4'b0000) $display("FAIL reset_strobes got=%b exp=0000", {rd_rdy, rda_rdy, wr_rdy, wra_rdy}); else n_pass++;
    n_checks++; if ({data_active, rw_done, q_full} !== 3'b000) $display("FAIL reset_active got=%b exp=000", {data_active, rw_done, q_full}); else n_pass++;
    n_checks++; if (q_count !== 4'd0) $display("FAIL reset_qcount got=%0d exp=0", q_count); else n_pass++;
    n_checks++; if ({overflow_err, collision_err, order_err} !== 3'b000) $display("FAIL reset_errs got=%b exp=000", {overflow_err, collision_err, order_err}); else n_pass++;
    n_checks++; if (data_idle !== 1'b1) $display("FAIL reset_idle got=%b exp=1", data_idle); else n_pass++;
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic test_single_rd;
    apply_reset();
    CL = 5'd11; AL = 5'd0; RD_PRE = 2'd1;
    push(1, 0);
    idle(30);
    n_checks++; if (o_edge.size() != 1) $display("FAIL single_count got=%0d exp=1", o_edge.size()); else n_pass++;
    if (o_edge.size() == 1) begin
      n_checks++; if (o_edge[0] - p_edge[0] != 12 || o_typ[0] != 1) $display("FAIL single_lat got=%0d/type%0d exp=12/type1", o_edge[0] - p_edge[0], o_typ[0]); else n_pass++;
      n_checks++; if (act_edge.size() != 4 || act_edge[0] != o_edge[0] || act_edge[3] != o_edge[0] + 3) $display("FAIL single_active got=%0d clocks exp=4 from strobe", act_edge.size()); else n_pass++;
      n_checks++; if (done_edge.size() != 1 || done_edge[0] != o_edge[0] + 3) $display("FAIL single_done got=%0d pulses exp=1 on 4th clock", done_edge.size()); else n_pass++;
    end
    n_checks++; if (data_idle !== 1'b1) $display("FAIL single_idle got=%b exp=1", data_idle); else n_pass++;
  endtask

  task automatic test_back_to_back;
    apply_reset();
    CWL = 5'd9; AL = 5'd2; WR_PRE = 2'd1;
    push(4, 0);
    idle(3);
    push(3, 0);
    idle(40);
    n_checks++; if (o_edge.size() != 2) $display("FAIL b2b_count got=%0d exp=2", o_edge.size()); else n_pass++;
    if (o_edge.size() == 2) begin
      n_checks++; if (o_typ[0] != 4 || o_edge[0] - p_edge[0] != 12) $display("FAIL b2b_wra got=type%0d@%0d exp=type4@12", o_typ[0], o_edge[0] - p_edge[0]); else n_pass++;
      n_checks++; if (o_typ[1] != 3 || o_edge[1] - p_edge[0] != 16) $display("FAIL b2b_wr got=type%0d@%0d exp=type3@16", o_typ[1], o_edge[1] - p_edge[0]); else n_pass++;
      n_checks++; if (act_edge.size() != 8 || act_edge[7] - act_edge[0] != 7 || act_edge[0] != o_edge[0]) $display("FAIL b2b_active got=%0d clocks exp=8 continuous", act_edge.size()); else n_pass++;
    end
    n_checks++; if (collision_err !== 1'b0) $display("FAIL b2b_collision got=%b exp=0", collision_err); else n_pass++;
  endtask

  task automatic test_collision;
    apply_reset();
    CL = 5'd11; AL = 5'd0; RD_PRE = 2'd1;
    push(1, 0);
    idle(1);
    push(1, 0);
    idle(40);
    n_checks++; if (o_edge.size() != 2) $display("FAIL coll_count got=%0d exp=2", o_edge.size()); else n_pass++;
    if (o_edge.size() == 2) begin
      n_checks++; if (o_edge[1] - o_edge[0] != 4) $display("FAIL coll_spacing got=%0d exp=4", o_edge[1] - o_edge[0]); else n_pass++;
      n_checks++; if (o_edge[1] - p_edge[1] != 14) $display("FAIL coll_stall got=%0d exp=14", o_edge[1] - p_edge[1]); else n_pass++;
    end
    n_checks++; if ({collision_err, order_err} !== 2'b10) $display("FAIL coll_flags got=%b exp=10", {collision_err, order_err}); else n_pass++;
  endtask

  task automatic test_overflow;
    apply_reset();
    CL = 5'd31; AL = 5'd0; RD_PRE = 2'd0;
    for (int k = 0; k < 8; k++) push(1, 0);
    n_checks++; if (q_full !== 1'b1 || q_count !== 4'd8) $display("FAIL ovf_full got=%b/%0d exp=1/8", q_full, q_count); else n_pass++;
    n_checks++; if (overflow_err !== 1'b0) $display("FAIL ovf_early got=%b exp=0", overflow_err); else n_pass++;
    push(1, 0);
    n_checks++; if (overflow_err !== 1'b1 || q_count !== 4'd8) $display("FAIL ovf_drop got=%b/%0d exp=1/8", overflow_err, q_count); else n_pass++;
    idle(80);
    n_checks++; if (o_edge.size() != 8 || done_edge.size() != 8) $display("FAIL ovf_bursts got=%0d/%0d exp=8/8", o_edge.size(), done_edge.size()); else n_pass++;
    n_checks++; if (data_idle !== 1'b1 || q_full !== 1'b0) $display("FAIL ovf_drain got=%b/%b exp=1/0", data_idle, q_full); else n_pass++;
  endtask

  task automatic test_order;
    apply_reset();
    CWL = 5'd20; CL = 5'd11; AL = 5'd0; WR_PRE = 2'd1; RD_PRE = 2'd1;
    push(3, 0);
    push(1, 0);
    idle(50);
    n_checks++; if (order_err !== 1'b1) $display("FAIL order_flag got=%b exp=1", order_err); else n_pass++;
    n_checks++; if (o_edge.size() != 2) $display("FAIL order_count got=%0d exp=2", o_edge.size()); else n_pass++;
    if (o_edge.size() == 2) begin
      n_checks++; if (o_typ[0] != 3 || o_typ[1] != 1) $display("FAIL order_seq got=%0d,%0d exp=3,1", o_typ[0], o_typ[1]); else n_pass++;
      n_checks++; if (o_edge[0] - p_edge[0] != 21 || o_edge[1] - o_edge[0] != 4) $display("FAIL order_time got=%0d,+%0d exp=21,+4", o_edge[0] - p_edge[0], o_edge[1] - o_edge[0]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_burst;
    apply_reset();
    CL = 5'd11; AL = 5'd0; RD_PRE = 2'd1;
    for (int k = 0; k < 4; k++) push(1, 0);
    idle(10);
    n_checks++; if (data_active !== 1'b1 || q_count !== 4'd3) $display("FAIL midrst_pre got=%b/%0d exp=1/3", data_active, q_count); else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++; if ({rd_rdy, rda_rdy, wr_rdy, wra_rdy, data_active, rw_done, q_full} !== 7'b0) $display("FAIL midrst_outs got=%b exp=0000000", {rd_rdy, rda_rdy, wr_rdy, wra_rdy, data_active, rw_done, q_full}); else n_pass++;
    n_checks++; if (q_count !== 4'd0 || data_idle !== 1'b1) $display("FAIL midrst_q got=%0d/%b exp=0/1", q_count, data_idle); else n_pass++;
    @(negedge CK_t);
    reset = 1'b0;
    clear_logs();
    idle(40);
    n_checks++; if (o_edge.size() != 0 || act_edge.size() != 0) $display("FAIL midrst_after got=%0d strobes exp=0", o_edge.size()); else n_pass++;
    n_checks++; if (q_count !== 4'd0 || data_idle !== 1'b1) $display("FAIL midrst_final got=%0d/%b exp=0/1", q_count, data_idle); else n_pass++;
  endtask

  task automatic test_random;
    int code, n, act_exp;
    for (int it = 0; it < 6; it++) begin
      apply_reset();
      CL = 5'($urandom_range(0, 31)); CWL = 5'($urandom_range(0, 31)); AL = 5'($urandom_range(0, 31));
      RD_PRE = 2'($urandom_range(0, 3)); WR_PRE = 2'($urandom_range(0, 3));
      n = $urandom_range(4, 14);
      for (int k = 0; k < n; k++) begin
        code = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : $urandom_range(1, 4);
        if ($urandom_range(0, 5) == 0) begin
          cas_req = 3'(code); idle(1); cas_req = 3'd0;
        end
        push(code, $urandom_range(0, 1));
        idle($urandom_range(0, 4));
      end
      idle(320);
      model_run();
      n_checks++; if (o_edge.size() != m_launch.size()) $display("FAIL rnd%0d_count got=%0d exp=%0d", it, o_edge.size(), m_launch.size()); else n_pass++;
      if (o_edge.size() == m_launch.size() && done_edge.size() == m_launch.size()) begin
        for (int j = 0; j < m_launch.size(); j++) begin
          n_checks++;
          if (o_edge[j] != m_launch[j] || o_typ[j] != m_typ[j] || done_edge[j] != m_launch[j] + m_len[j] - 1)
            $display("FAIL rnd%0d_burst%0d got=type%0d@%0d done@%0d exp=type%0d@%0d done@%0d", it, j, o_typ[j], o_edge[j], done_edge[j], m_typ[j], m_launch[j], m_launch[j] + m_len[j] - 1);
          else n_pass++;
        end
      end
      act_exp = 0;
      foreach (m_len[j]) act_exp += m_len[j];
      n_checks++; if (act_edge.size() != act_exp || done_edge.size() != m_launch.size()) $display("FAIL rnd%0d_active got=%0d/%0d exp=%0d/%0d", it, act_edge.size(), done_edge.size(), act_exp, m_launch.size()); else n_pass++;
      n_checks++; if ({overflow_err, collision_err, order_err} !== {m_ovf, m_coll, m_ord}) $display("FAIL rnd%0d_errs got=%b exp=%b", it, {overflow_err, collision_err, order_err}, {m_ovf, m_coll, m_ord}); else n_pass++;
      n_checks++; if (data_idle !== 1'b1 || q_count !== 4'd0) $display("FAIL rnd%0d_idle got=%b/%0d exp=1/0", it, data_idle, q_count); else n_pass++;
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_rd();
    test_back_to_back();
    test_collision();
    test_overflow();
    test_order();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
